step_controller: RTL and testbench

Front-end clock-enable generator for the RISC core on the DE1-SoC board. It converts a raw, bouncy pushbutton and a run/step switch into a clean single-cycle `step_en` pulse in the `CLOCK_50` domain. The CPU datapath advances exactly one instruction-step per pulse, so the core runs on `CLOCK_50` with an enable instead of being clocked by a key. A free-run mode issues pulses at a fixed divided rate, and a halt input from the core freezes stepping.

---
 rtl/risc_pkg.sv | 5 +
 rtl/key_debounce.sv | 48 ++++
 rtl/step_controller.sv | 75 +++++++
 tb/tb_step_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared step-controller state encoding and DE1-SoC board constants
package risc_pkg;
  localparam int CLK_HZ = 50_000_000;
  typedef enum logic [1:0] {STEP_IDLE, STEP_HELD, RUN, HALTED} step_state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stable-count debouncer and press strobe for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_db,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q;
  logic db_q, db_d, press_q, press_d, armed_q, armed_d;
  logic [1:0] prime_q, prime_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // armed only after a real released sample, so a key held through reset never strobes
  always_comb begin
    prime_d = {prime_q[0], 1'b1};
    cnt_d = '0;
    db_d = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = s2_q;
      else cnt_d = cnt_q + 1'b1;
    end
    armed_d = armed_q | (prime_q[1] & s2_q);
    press_d = armed_q & db_q & ~db_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      db_q <= 1'b1;
      cnt_q <= '0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      prime_q <= '0;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
      armed_q <= armed_d;
      prime_q <= prime_d;
    end
  assign key_db = db_q;
  assign press = press_q;
endmodule

// File: rtl/step_controller.sv
// step_controller: debounced single-step / free-run / halt clock-enable generator for the RISC core
module step_controller
  import risc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV = 25_000_000,
  parameter int CNT_W = 16
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             step_key_n,
  input  logic             run_sw,
  input  logic             halt,
  output logic             step_en,
  output logic [CNT_W-1:0] step_count,
  output logic             mode_run,
  output logic             halted
);
  localparam int DIV_W = $clog2(RUN_DIV);
  step_state_t state_q, state_d;
  logic run_s1_q, run_s2_q;
  logic en_q, en_d, key_db, press;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk(CLOCK_50), .rst_n(resetn), .key_n(step_key_n), .key_db(key_db), .press(press)
  );
  // divider defaults to 0 so every exit from RUN clears it
  always_comb begin
    state_d = state_q;
    div_d = '0;
    en_d = 1'b0;
    cnt_d = cnt_q + CNT_W'(en_q);
    case (state_q)
      STEP_IDLE:
        if (halt) state_d = HALTED;
        else if (run_s2_q) state_d = RUN;
        else if (press) begin
          state_d = STEP_HELD;
          en_d = 1'b1;
        end
      STEP_HELD:
        if (halt) state_d = HALTED;
        else if (key_db) state_d = STEP_IDLE;
      RUN:
        if (halt) state_d = HALTED;
        else if (!run_s2_q) state_d = STEP_IDLE;
        else if (div_q == DIV_W'(RUN_DIV - 1)) en_d = 1'b1;
        else div_d = div_q + 1'b1;
      HALTED:
        if (!halt) state_d = STEP_IDLE;
      default: state_d = STEP_IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state_q <= STEP_IDLE;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      en_q <= 1'b0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      run_s1_q <= run_sw;
      run_s2_q <= run_s1_q;
      en_q <= en_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  assign step_en = en_q;
  assign step_count = cnt_q;
  assign mode_run = (state_q == RUN);
  assign halted = (state_q == HALTED);
endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: randomized and directed checks of step_controller against a behavioural model
module tb_step_controller;
  localparam int DEB = 4;
  localparam int DIV = 5;
  localparam int CW = 4;
  logic clk, resetn, step_key_n, run_sw, halt;
  logic step_en, mode_run, halted;
  logic [CW-1:0] step_count;
  int checks = 0, failures = 0, cyc = 0, pulses = 0, first_pulse = -1;
  int t0, p0;
  bit prev_en = 0;
  // model state: mode 0 idle, 1 held, 2 run, 3 halted
  int m_n, m_stab, m_mode, m_age, m_cnt, mode_n;
  bit m_k1, m_sync, m_r1, m_rs, m_db, m_armed, m_press, m_en, en_n, db_n;

  step_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(DIV), .CNT_W(CW)) dut (
    .CLOCK_50(clk), .resetn(resetn), .step_key_n(step_key_n), .run_sw(run_sw), .halt(halt),
    .step_en(step_en), .step_count(step_count), .mode_run(mode_run), .halted(halted)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_n = 0; m_k1 = 1; m_sync = 1; m_r1 = 0; m_rs = 0; m_db = 1; m_stab = 0;
      m_armed = 0; m_press = 0; m_mode = 0; m_age = 0; m_en = 0; m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + int'(m_en)) % (1 << CW);
      en_n = 0;
      mode_n = m_mode;
      case (m_mode)
        0: if (halt) mode_n = 3;
           else if (m_rs) begin mode_n = 2; m_age = 0; end
           else if (m_press) begin mode_n = 1; en_n = 1; end
        1: if (halt) mode_n = 3; else if (m_db) mode_n = 0;
        2: if (halt) mode_n = 3;
           else if (!m_rs) mode_n = 0;
           else begin m_age++; en_n = (m_age % DIV) == 0; end
        default: if (!halt) mode_n = 0;
      endcase
      db_n = m_db;
      if (m_sync != m_db) begin
        m_stab++;
        if (m_stab == DEB) begin db_n = m_sync; m_stab = 0; end
      end else m_stab = 0;
      m_press = m_armed && m_db && !db_n;
      if (m_n >= 2 && m_sync) m_armed = 1;
      m_db = db_n;
      m_sync = m_k1; m_k1 = step_key_n;
      m_rs = m_r1; m_r1 = run_sw;
      if (m_n < 2) m_n++;
      m_mode = mode_n;
      m_en = en_n;
    end
  end

  always @(negedge clk) begin
    chk("step_en", int'(step_en), int'(m_en));
    chk("step_count", int'(step_count), m_cnt);
    chk("mode_run", int'(mode_run), int'(m_mode == 2));
    chk("halted", int'(halted), int'(m_mode == 3));
    if (step_en && prev_en) chk("back_to_back", 1, 0);
    prev_en = step_en;
    if (step_en) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  end

  initial begin
    resetn = 0; step_key_n = 1; run_sw = 0; halt = 0;
    tick(3);
    resetn = 1;
    tick(5);
    // clean press
    first_pulse = -1; p0 = pulses; t0 = cyc;
    step_key_n = 0;
    tick(20);
    chk("press_latency", first_pulse - t0, 7);
    chk("press_pulses", pulses - p0, 1);
    chk("press_count", int'(step_count), 1);
    step_key_n = 1;
    tick(10);
    // bounce shorter than the debounce window
    p0 = pulses;
    repeat (3) begin
      step_key_n = 0; tick(2);
      step_key_n = 1; tick(2);
    end
    tick(10);
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_count", int'(step_count), 1);
    // free run, four pulses
    first_pulse = -1; p0 = pulses; t0 = cyc;
    run_sw = 1;
    tick(24);
    chk("run_mode", int'(mode_run), 1);
    run_sw = 0;
    tick(10);
    chk("run_first", first_pulse - t0, 8);
    chk("run_pulses", pulses - p0, 4);
    chk("run_count", int'(step_count), 5);
    chk("run_exit", int'(mode_run), 0);
    // halt on the divider-at-4 cycle
    p0 = pulses; t0 = cyc;
    run_sw = 1;
    tick(7);
    halt = 1;
    tick(3);
    chk("halt_state", int'(halted), 1);
    chk("halt_pulses", pulses - p0, 0);
    run_sw = 0;
    tick(4);
    halt = 0;
    tick(5);
    chk("halt_release", int'(halted), 0);
    chk("halt_idle", int'(mode_run), 0);
    chk("halt_nopulse", pulses - p0, 0);
    step_key_n = 0; tick(12);
    step_key_n = 1; tick(10);
    chk("fresh_press", pulses - p0, 1);
    chk("fresh_count", int'(step_count), 6);
    // sixteen run pulses wrap the 4-bit counter back to the same value
    p0 = pulses;
    run_sw = 1;
    tick(84);
    run_sw = 0;
    tick(10);
    chk("wrap_pulses", pulses - p0, 16);
    chk("wrap_count", int'(step_count), 6);
    // asynchronous reset mid-debounce, key still held afterwards
    step_key_n = 0;
    tick(4);
    @(posedge clk); #2;
    resetn = 0;
    #1;
    chk("rst_en", int'(step_en), 0);
    chk("rst_count", int'(step_count), 0);
    chk("rst_run", int'(mode_run), 0);
    chk("rst_halted", int'(halted), 0);
    tick(2);
    resetn = 1;
    p0 = pulses;
    tick(30);
    chk("held_after_rst", pulses - p0, 0);
    step_key_n = 1; tick(10);
    step_key_n = 0; tick(12);
    step_key_n = 1; tick(10);
    chk("press_after_rst", pulses - p0, 1);
    chk("count_after_rst", int'(step_count), 1);
    // randomized key, switch and halt activity
    for (int i = 0; i < 400; i++) begin
      step_key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) run_sw = ~run_sw;
      halt = ($urandom_range(0, 15) == 0);
      tick($urandom_range(1, 12));
    end
    step_key_n = 1; run_sw = 0; halt = 0;
    tick(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
